// File: rtl/core_pkg.sv
// Shared constants and pipeline-register payload types for the 5-stage core.
package core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned REG_ADDR_W = 5;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic                valid;
        logic [INSTR_W-1:0]  instr;
        logic [XLEN-1:0]     pc;
    } if_id_t;

    // Empty pipeline slot: not valid, NOP opcode, zero address
    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: INSTR_NOP, pc: '0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and bubble-injecting flush (flush beats hold).
module if_id_reg
    import core_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   hold_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    // Flush inserts a bubble, hold keeps the current slot, otherwise load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= IF_ID_BUBBLE;
        end else if (flush_i) begin
            q_o <= IF_ID_BUBBLE;
        end else if (!hold_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, the IF/ID register and the stall/flush counters.
module fetch_stage #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0,
    parameter int unsigned          CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic [XLEN-1:0]   imem_addr_o,
    input  logic [31:0]       imem_data_i,
    output logic              decode_valid_o,
    output logic [31:0]       decode_instr_o,
    output logic [XLEN-1:0]   decode_pc_o,
    output logic [XLEN-1:0]   decode_pc_plus4_o,
    output logic [4:0]        decode_rs1_addr_o,
    output logic [4:0]        decode_rs2_addr_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    import core_pkg::*;

    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0]  ALIGN_MSK = ~XLEN'(3);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    if_id_t           if_id_d;
    if_id_t           if_id_q;

    // Next PC: redirect (word-aligned) beats stall, otherwise sequential (wraps)
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i & ALIGN_MSK;
        end else if (!stall_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // Program counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Candidate IF/ID contents: the word fetched this cycle at pc_q
    always_comb begin
        if_id_d       = IF_ID_BUBBLE;
        if_id_d.valid = 1'b1;
        if_id_d.instr = imem_data_i;
        if_id_d.pc    = pc_q;
    end

    if_id_reg u_if_id (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hold_i  (stall_i),
        .flush_i (redirect_i),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    // Saturating counters: redirects taken, and stall cycles that held a real instruction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (redirect_i) begin
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end else if (stall_i && if_id_q.valid) begin
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Bubbles report x0 sources so they never look like a hazard
    always_comb begin
        decode_rs1_addr_o = '0;
        decode_rs2_addr_o = '0;
        if (if_id_q.valid) begin
            decode_rs1_addr_o = if_id_q.instr[RS1_LSB +: REG_ADDR_W];
            decode_rs2_addr_o = if_id_q.instr[RS2_LSB +: REG_ADDR_W];
        end
    end

    assign imem_addr_o       = pc_q;
    assign decode_valid_o    = if_id_q.valid;
    assign decode_instr_o    = if_id_q.instr;
    assign decode_pc_o       = if_id_q.pc;
    assign decode_pc_plus4_o = if_id_q.pc + PC_STEP;
    assign stall_cnt_o       = stall_cnt_q;
    assign flush_cnt_o       = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random stall/redirect traffic.
module tb_fetch_stage;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_SAT = 15;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_data;
    logic              decode_valid;
    logic [31:0]       decode_instr;
    logic [31:0]       decode_pc;
    logic [31:0]       decode_pc_plus4;
    logic [4:0]        decode_rs1_addr;
    logic [4:0]        decode_rs2_addr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: what the fetch stage should hold, in plain terms
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_dpc;
    int          m_scnt;
    int          m_fcnt;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .stall_i           (stall),
        .redirect_i        (redirect),
        .redirect_pc_i     (redirect_pc),
        .imem_addr_o       (imem_addr),
        .imem_data_i       (imem_data),
        .decode_valid_o    (decode_valid),
        .decode_instr_o    (decode_instr),
        .decode_pc_o       (decode_pc),
        .decode_pc_plus4_o (decode_pc_plus4),
        .decode_rs1_addr_o (decode_rs1_addr),
        .decode_rs2_addr_o (decode_rs2_addr),
        .stall_cnt_o       (stall_cnt),
        .flush_cnt_o       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at 0, an address hash elsewhere
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_data = imem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_instr = NOP;
        m_dpc   = 32'h0;
        m_scnt  = 0;
        m_fcnt  = 0;
    endtask

    task automatic model_edge(input logic s, input logic r, input logic [31:0] rpc,
                              input logic [31:0] word);
        if (r) begin
            m_pc    = rpc - (rpc % 4);
            m_valid = 1'b0;
            m_instr = NOP;
            m_dpc   = 32'h0;
            if (m_fcnt < CNT_SAT) m_fcnt++;
        end else if (s) begin
            if (m_valid && m_scnt < CNT_SAT) m_scnt++;
        end else begin
            m_valid = 1'b1;
            m_instr = word;
            m_dpc   = m_pc;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] rs1_exp;
        logic [31:0] rs2_exp;
        rs1_exp = m_valid ? ((m_instr >> 15) & 32'h1F) : 32'h0;
        rs2_exp = m_valid ? ((m_instr >> 20) & 32'h1F) : 32'h0;
        check({tag, ".imem_addr"}, imem_addr, m_pc);
        check({tag, ".valid"}, 32'(decode_valid), 32'(m_valid));
        check({tag, ".instr"}, decode_instr, m_instr);
        check({tag, ".pc"}, decode_pc, m_dpc);
        check({tag, ".pc4"}, decode_pc_plus4, m_dpc + 32'd4);
        check({tag, ".rs1"}, 32'(decode_rs1_addr), rs1_exp);
        check({tag, ".rs2"}, 32'(decode_rs2_addr), rs2_exp);
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_scnt));
        check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_fcnt));
    endtask

    // One clock: drive at the current (negedge) point, check #1 after the rising edge
    task automatic cycle(input string tag, input logic s, input logic r, input logic [31:0] rpc);
        logic [31:0] word;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        word        = imem_word(m_pc);
        @(posedge clk);
        model_edge(s, r, rpc, word);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // First fetch after reset release
        cycle("first", 1'b0, 1'b0, 32'h0);
        check("first.instr_k", decode_instr, 32'h00A0_0093);
        check("first.rs2_k", 32'(decode_rs2_addr), 32'd10);
        check("first.addr_k", imem_addr, 32'd4);
        cycle("fetch2", 1'b0, 1'b0, 32'h0);

        // Stall three cycles with pc at 8
        for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0, 32'h0);
        check("stall.addr_k", imem_addr, 32'd8);
        check("stall.dpc_k", decode_pc, 32'd4);
        check("stall.cnt_k", 32'(stall_cnt), 32'd3);
        cycle("release", 1'b0, 1'b0, 32'h0);
        check("release.addr_k", imem_addr, 32'd12);

        // Redirect with simultaneous stall: redirect wins, low bits dropped
        cycle("redir_stall", 1'b1, 1'b1, 32'h0000_0103);
        check("redir.addr_k", imem_addr, 32'h0000_0100);
        check("redir.valid_k", 32'(decode_valid), 32'd0);
        check("redir.instr_k", decode_instr, NOP);
        check("redir.flush_k", 32'(flush_cnt), 32'd1);
        check("redir.stall_k", 32'(stall_cnt), 32'd3);

        // PC wrap at the top of the address space
        cycle("to_top", 1'b0, 1'b1, 32'hFFFF_FFFE);
        cycle("wrap", 1'b0, 1'b0, 32'h0);
        check("wrap.addr_k", imem_addr, 32'h0);
        check("wrap.dpc_k", decode_pc, 32'hFFFF_FFFC);
        check("wrap.pc4_k", decode_pc_plus4, 32'h0);

        // Asynchronous reset mid-cycle after five fetches
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst.addr_k", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Stall counter saturation with a valid instruction parked in decode
        cycle("sat_fill", 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) cycle("sat", 1'b1, 1'b0, 32'h0);
        check("sat.cnt_k", 32'(stall_cnt), 32'hF);

        // Random stall/redirect traffic
        for (int i = 0; i < 400; i++) begin
            logic s;
            logic r;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            cycle("rand", s, r, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage in-order core.
- Owns the program counter and the IF/ID pipeline register.
- Consumes the hazard unit's stall and the execute stage's branch/jump redirect.
- Produces the decode-stage instruction, PC and source register addresses, which the hazard unit compares against EX/MEM/WB destinations.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the performance counters.

Ports:
- clk_i  input  1  core clock, rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- stall_i  input  1  hazard-unit stall; holds the PC and IF/ID.
- redirect_i  input  1  execute-stage taken branch/jump.
- redirect_pc_i  input  XLEN  redirect target.
- imem_addr_o  output  XLEN  instruction memory address (combinational read).
- imem_data_i  input  32  instruction word at imem_addr_o, same cycle.
- decode_valid_o  output  1  IF/ID holds a real instruction.
- decode_instr_o  output  32  IF/ID instruction.
- decode_pc_o  output  XLEN  IF/ID instruction address.
- decode_pc_plus4_o  output  XLEN  decode_pc_o + 4.
- decode_rs1_addr_o  output  5  instr[19:15] when valid, else 0.
- decode_rs2_addr_o  output  5  instr[24:20] when valid, else 0.
- stall_cnt_o  output  CNT_W  cycles lost to stall.
- flush_cnt_o  output  CNT_W  redirects taken.

Behaviour:
- Reset (async, rst_i=1):
  - pc_q = RESET_PC.
  - decode_valid_o = 0, decode_instr_o = NOP (32'h0000_0013), decode_pc_o = 0.
  - Both counters = 0.
  - Reset asserted mid-operation discards all in-flight state immediately, with no clock edge needed.
- imem_addr_o = pc_q at all times. Instruction memory latency is 0 cycles (combinational).
- Per-cycle update, evaluated in priority order:
  1. redirect_i=1:
     - pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00}; the low bits are silently cleared.
     - IF/ID <= bubble (valid=0, instr=NOP, pc=0).
     - Redirect wins over a simultaneous stall_i.
     - flush_cnt += 1.
  2. stall_i=1, redirect_i=0:
     - pc_q and IF/ID hold their values.
     - The instruction already in decode is re-presented unchanged next cycle.
     - stall_cnt += 1 only if decode_valid_o=1.
  3. Otherwise:
     - pc_q <= pc_q + 4.
     - IF/ID <= {valid=1, instr=imem_data_i, pc=pc_q}.
- Latency:
  - An instruction at pc_q appears on decode_* one cycle later.
  - First valid decode is the cycle after the first edge following reset release.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- decode_rs1_addr_o / decode_rs2_addr_o are forced to 0 when valid=0. Bubbles must never raise a false hazard stall (the hazard unit ignores x0).
- decode_pc_plus4_o is combinational from decode_pc_o and also wraps.
- Counters saturate at all-ones and do not wrap.
- Stall held for N consecutive cycles: exactly one instruction stays in decode, and the PC advances again on the first non-stall cycle.
- Redirect in the first cycle after reset release is honoured; no special-casing.

Decomposition:
- core_pkg:
  - XLEN and INSTR_NOP constants.
  - Field-position localparams RS1_LSB=15, RS2_LSB=20, REG_ADDR_W=5.
  - Typedef if_id_t {logic valid; logic [31:0] instr; logic [XLEN-1:0] pc;}.
- Sub-module if_id_reg:
  - Async-reset register of if_id_t with hold (stall) and flush (bubble) controls, flush over hold.
  - Reused by the later ID/EX stage, which consumes the hazard unit's flushE.
- The PC register and saturating counters stay in fetch_stage.

Test Plan:
- Reset, RESET_PC=0, imem returns 32'h00A00093 at 0 -> after 1 edge: decode_valid=1, decode_instr=32'h00A00093, decode_pc=0, decode_pc_plus4=4, imem_addr=4, rs1=0, rs2=10.
- stall_i high 3 cycles with pc_q=8 -> imem_addr stays 8, decode_instr/decode_pc unchanged, stall_cnt=3; the cycle after release gives imem_addr=12.
- redirect_i=1, redirect_pc_i=32'h0000_0103, stall_i=1 same cycle -> next cycle pc_q=32'h100, decode_valid=0, decode_instr=NOP, rs1=rs2=0, flush_cnt=1, stall_cnt unchanged.
- pc_q=32'hFFFF_FFFC, no stall -> next imem_addr=0, decode_pc=32'hFFFF_FFFC, decode_pc_plus4=0.
- Assert rst_i asynchronously mid-cycle after 5 fetches -> outputs return to reset values before the next edge, counters 0, imem_addr=RESET_PC.
- CNT_W=4, stall with valid decode for 20 cycles -> stall_cnt saturates at 4'hF.
